encoder_8b10b: RTL and testbench

//  8b/10b line encoder (IEEE 802.3 Cl.36 / Widmer-Franaszek). Transmit-side companion of the link

---
 rtl/encoder_8b10b.sv | 151 +++++++++++++++
 tb/tb_encoder_8b10b.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8b10b.sv
// 8b/10b line encoder with running-disparity control.
// One byte plus K flag in per enabled cycle, one registered 10-bit symbol out.
module encoder_8b10b #(
    parameter logic INIT_RD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] din,
    input  logic       kin,
    output logic [9:0] dout,
    output logic       kerr,
    output logic       disp,
    output logic       vld
);

    // RD- column of the 5b/6b table, abcdei with a in bit 5
    function automatic logic [5:0] enc5b(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            5'd31:   c = 6'b101011;
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    // RD- column of the 3b/4b table, fghj with f in bit 3
    function automatic logic [3:0] enc3b(input logic [2:0] y, input logic alt);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            3'd7:    c = alt ? 4'b0111 : 4'b1110;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]) + 3'(v[5]);
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    logic [9:0] dout_q, dout_d;
    logic       kerr_q, kerr_d;
    logic       rd_q, rd_d;
    logic       vld_q;

    logic [4:0] x_s;
    logic [2:0] y_s;
    logic       k28_s, k_ok_s, unbal6_s, rd6_s, alt7_s, comp4_s;
    logic [5:0] c6_s;
    logic [3:0] c4_s;

    // Symbol construction from the byte, K flag and current running disparity
    always_comb begin
        x_s      = din[4:0];
        y_s      = din[7:5];
        k28_s    = (x_s == 5'd28);
        k_ok_s   = kin && (k28_s || ((y_s == 3'd7) &&
                   ((x_s == 5'd23) || (x_s == 5'd27) || (x_s == 5'd29) || (x_s == 5'd30))));
        kerr_d   = kin && !k_ok_s;

        c6_s     = (k_ok_s && k28_s) ? 6'b001111 : enc5b(x_s);
        unbal6_s = (ones6(c6_s) != 3'd3);
        rd6_s    = rd_q ^ unbal6_s;

        // Alternate D.x.7 avoids a run of five across the 6b/4b boundary
        alt7_s   = k_ok_s ||
                   (!rd6_s && ((x_s == 5'd17) || (x_s == 5'd18) || (x_s == 5'd20))) ||
                   ( rd6_s && ((x_s == 5'd11) || (x_s == 5'd13) || (x_s == 5'd14)));
        c4_s     = enc3b(y_s, alt7_s);

        // K28 balanced 4b halves are inverted relative to data on the RD- side
        if (rd6_s) begin
            comp4_s = (ones4(c4_s) != 3'd2) || (y_s == 3'd3);
        end else begin
            comp4_s = k_ok_s && k28_s &&
                      ((y_s == 3'd1) || (y_s == 3'd2) || (y_s == 3'd5) || (y_s == 3'd6));
        end

        dout_d[9:4] = (rd_q && (unbal6_s || (x_s == 5'd7))) ? ~c6_s : c6_s;
        dout_d[3:0] = comp4_s ? ~c4_s : c4_s;
        rd_d        = rd6_s ^ (ones4(c4_s) != 3'd2);
    end

    // Output and running-disparity registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= 10'h000;
            kerr_q <= 1'b0;
            rd_q   <= INIT_RD;
            vld_q  <= 1'b0;
        end else if (en) begin
            dout_q <= dout_d;
            kerr_q <= kerr_d;
            rd_q   <= rd_d;
            vld_q  <= 1'b1;
        end else begin
            dout_q <= dout_q;
            kerr_q <= kerr_q;
            rd_q   <= rd_q;
            vld_q  <= 1'b0;
        end
    end

    assign dout = dout_q;
    assign kerr = kerr_q;
    assign disp = rd_q;
    assign vld  = vld_q;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Scoreboard bench for encoder_8b10b: table-driven reference model, directed
// cases followed by code sweeps and randomized traffic.
module tb_encoder_8b10b;

    localparam logic INIT = 1'b0;

    logic       clk = 1'b0;
    logic       rst, en, kin;
    logic [7:0] din;
    logic [9:0] dout;
    logic       kerr, disp, vld;

    always #5 clk = ~clk;

    encoder_8b10b #(.INIT_RD(INIT)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .kin(kin),
        .dout(dout), .kerr(kerr), .disp(disp), .vld(vld)
    );

    typedef struct packed {
        logic       vld;
        logic [9:0] dout;
        logic       kerr;
        logic       disp;
        logic       comma;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    localparam logic [5:0] LUT6 [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] LUT4N [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                           4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] LUT4P [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                           4'b0010, 4'b1010, 4'b0110, 4'b0001};
    // Complete K28.y symbols entered from RD-; the RD+ symbols are their complements
    localparam logic [9:0] K28N [0:7] = '{10'h0F4, 10'h0F9, 10'h0F5, 10'h0F3,
                                          10'h0F2, 10'h0FA, 10'h0F6, 10'h0F8};
    localparam logic [7:0] KLIST [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                            8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    logic       m_rd = INIT;
    logic [9:0] m_dout = 10'h000;
    logic       m_kerr = 1'b0;

    function automatic int ones(input logic [9:0] v);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int maxrun(input logic [9:0] v);
        int best = 1;
        int cur = 1;
        for (int i = 1; i < 10; i++) begin
            cur = (v[i] == v[i-1]) ? cur + 1 : 1;
            if (cur > best) best = cur;
        end
        return best;
    endfunction

    task automatic model_apply(input logic r, input logic e, input logic k,
                               input logic [7:0] d, output exp_t ex);
        logic [4:0] x;
        logic [2:0] y;
        logic       legal, rd6, comma;
        logic [5:0] c6;
        logic [3:0] c4;
        logic [9:0] sym;
        x = d[4:0];
        y = d[7:5];
        comma = 1'b0;
        if (r) begin
            m_rd = INIT; m_dout = 10'h000; m_kerr = 1'b0;
            ex = '{vld: 1'b0, dout: 10'h000, kerr: 1'b0, disp: INIT, comma: 1'b0};
        end else if (e) begin
            legal = k && (x == 5'd28 || d == 8'hF7 || d == 8'hFB || d == 8'hFD || d == 8'hFE);
            if (legal && x == 5'd28) begin
                sym   = m_rd ? ~K28N[y] : K28N[y];
                comma = (y == 3'd1) || (y == 3'd5) || (y == 3'd7);
            end else begin
                c6 = LUT6[x];
                if (m_rd && (ones({4'b0000, c6}) != 3 || x == 5'd7)) c6 = ~c6;
                rd6 = m_rd ^ (ones({4'b0000, c6}) != 3);
                if (y == 3'd7 && (legal || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                                  (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
                    c4 = rd6 ? 4'b1000 : 4'b0111;
                else
                    c4 = rd6 ? LUT4P[y] : LUT4N[y];
                sym = {c6, c4};
            end
            // A symbol with non-zero disparity flips the running disparity
            m_rd   = m_rd ^ (ones(sym) != 5);
            m_dout = sym;
            m_kerr = k && !legal;
            ex = '{vld: 1'b1, dout: m_dout, kerr: m_kerr, disp: m_rd, comma: comma};
        end else begin
            ex = '{vld: 1'b0, dout: m_dout, kerr: m_kerr, disp: m_rd, comma: 1'b0};
        end
    endtask

    task automatic step(input logic r, input logic e, input logic k, input logic [7:0] d,
                        input logic use_c, input logic [9:0] c_dout);
        exp_t ex;
        rst = r; en = e; kin = k; din = d;
        @(posedge clk);
        #1;
        model_apply(r, e, k, d, ex);
        if (use_c) ex.dout = c_dout;
        sbq.push_back(ex);
    endtask

    task automatic chk(input string nm, input logic [9:0] a, input logic [9:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
        end
    endtask

    exp_t mon_ex;
    int   mon_n;

    // Monitor: one expectation per clock, sampled on the falling edge
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_ex = sbq.pop_front();
            chk("vld",  {9'd0, vld},  {9'd0, mon_ex.vld});
            chk("dout", dout,         mon_ex.dout);
            chk("kerr", {9'd0, kerr}, {9'd0, mon_ex.kerr});
            chk("disp", {9'd0, disp}, {9'd0, mon_ex.disp});
            if (mon_ex.vld) begin
                mon_n = ones(dout);
                chk("disparity", {9'd0, (mon_n >= 4 && mon_n <= 6)}, 10'd1);
                if (!mon_ex.comma) chk("runlength", {9'd0, (maxrun(dout) <= 5)}, 10'd1);
            end
        end
    end

    initial begin
        int budget;
        logic [7:0] rb;
        rst = 1'b1; en = 1'b0; kin = 1'b0; din = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 10'h000);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 10'h274);
        step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b1, 10'h0FA);
        step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b1, 10'h305);
        step(1'b0, 1'b1, 1'b0, 8'hB5, 1'b1, 10'h2AA);
        step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b1, 10'h0FA);
        step(1'b0, 1'b1, 1'b0, 8'hB5, 1'b1, 10'h2AA);
        step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b1, 10'h305);
        step(1'b0, 1'b1, 1'b0, 8'hF1, 1'b1, 10'h237);
        step(1'b0, 1'b1, 1'b0, 8'hE0, 1'b1, 10'h18E);
        step(1'b0, 1'b1, 1'b1, 8'hBC, 1'b1, 10'h305);
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 10'h274);
        step(1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 10'h000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'(i % 2), 1'b1, 8'hBC, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b1, 8'hBC, 1'b1, 10'h000);
        step(1'b0, 1'b0, 1'b1, 8'hBC, 1'b0, 10'h000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2 == 0), 1'b1, 8'hBC, 1'b0, 10'h000);

        // Full code sweep, repeated after a K28.1 so every code is seen from both RDs
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 256; i++) begin
                step(1'b0, 1'b1, 1'b0, i[7:0], 1'b0, 10'h000);
                if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h000);
            end
            for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, KLIST[i], 1'b0, 10'h000);
            step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 10'h000);
        end

        for (int i = 0; i < 3000; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'b1,
                     ($urandom_range(0, 2) != 0) ? KLIST[$urandom_range(0, 11)] : rb,
                     1'b0, 10'h000);
            else
                step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'b0, rb,
                     1'b0, 10'h000);
        end
        en = 1'b0;
        rst = 1'b0;

        budget = 0;
        while (sbq.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
